// File: rtl/systolic_skew_feeder_if.sv
// rtl/systolic_skew_feeder_if.sv - tile load, stream command and skewed operand bus
interface systolic_skew_feeder_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
);
  logic                     clr;
  logic                     wr_en;
  logic [DIM*BITS_AB-1:0]   wr_data;
  logic                     wr_ready;
  logic                     start;
  logic                     full;
  logic                     out_valid;
  logic [DIM*BITS_AB-1:0]   a_out;
  logic                     done;

  modport master (
    output clr, wr_en, wr_data, start,
    input  wr_ready, full, out_valid, a_out, done
  );

  modport slave (
    input  clr, wr_en, wr_data, start,
    output wr_ready, full, out_valid, a_out, done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - buffers a DIM x DIM operand tile and streams it diagonally skewed
module systolic_skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_skew_feeder_if.slave bus
);
  localparam int W    = DIM * BITS_AB;
  localparam int PW   = $clog2(DIM);
  localparam int CW   = $clog2(2 * DIM - 1);
  localparam int LAST = 2 * DIM - 2;

  typedef enum logic [1:0] {IDLE, FULL, STREAM} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, done_q, wr_ready_q, full_q;
  logic [W-1:0]    a_out_q, a_out_d;
  logic            done_d;
  logic            beat_go;
  logic [CW-1:0]   beat_idx;
  logic [W-1:0]    tile [DIM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      a_out_q     <= '0;
      done_q      <= 1'b0;
      wr_ready_q  <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= beat_go;
      a_out_q     <= a_out_d;
      done_q      <= done_d;
      wr_ready_q  <= (state_d == IDLE);
      full_q      <= (state_d == FULL);
    end
  end

  // Storage is deliberately unreset: FULL is only reachable after all DIM rows are rewritten.
  always_ff @(posedge clk) begin
    if (!bus.clr && state_q == IDLE && bus.wr_en)
      tile[wr_ptr_q] <= bus.wr_data;
  end

  // beat_idx is the beat that will be presented in the cycle after this edge.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    beat_go  = 1'b0;
    beat_idx = '0;
    if (bus.clr) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.wr_en) begin
            if (wr_ptr_q == PW'(DIM - 1)) begin
              state_d  = FULL;
              wr_ptr_d = '0;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (bus.start) begin
            state_d  = STREAM;
            cnt_d    = '0;
            beat_go  = 1'b1;
            beat_idx = '0;
          end
        end
        STREAM: begin
          if (cnt_q == CW'(LAST)) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            beat_go  = 1'b1;
            beat_idx = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Lane i carries row (t - i); everything off the diagonal band stays exactly zero.
  always_comb begin
    a_out_d = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int i = 0; i < DIM; i++) begin
        if (beat_go && beat_idx == CW'(r + i))
          a_out_d[i*BITS_AB +: BITS_AB] = tile[r][i*BITS_AB +: BITS_AB];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.a_out     = a_out_q;
  assign bus.done      = done_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.full      = full_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed bench for systolic_skew_feeder with DIM=4, BITS_AB=8
module tb_systolic_skew_feeder;
  localparam int BITS_AB = 8;
  localparam int DIM     = 4;
  localparam int W       = DIM * BITS_AB;
  localparam int NBEATS  = 2 * DIM - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus();

  systolic_skew_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] tile_m [DIM];
  logic [W-1:0] beats  [NBEATS];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_beat(input int t);
    logic [W-1:0] v;
    int r;
    v = '0;
    for (int i = 0; i < DIM; i++) begin
      r = t - i;
      if (r >= 0 && r < DIM)
        v[i*BITS_AB +: BITS_AB] = tile_m[r][i*BITS_AB +: BITS_AB];
    end
    return v;
  endfunction

  task automatic set_tile(input int base);
    for (int r = 0; r < DIM; r++)
      for (int i = 0; i < DIM; i++)
        tile_m[r][i*BITS_AB +: BITS_AB] = 8'(base + 16 * r + i);
  endtask

  task automatic write_row(input int r);
    bus.wr_en   = 1'b1;
    bus.wr_data = tile_m[r];
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic load_tile(input string tag);
    for (int r = 0; r < DIM; r++)
      write_row(r);
    check({tag, " full"}, W'(bus.full), 1);
    check({tag, " wr_ready"}, W'(bus.wr_ready), 0);
  endtask

  task automatic run_stream(input string tag, input bit junk);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t < NBEATS; t++) begin
      beats[t] = bus.a_out;
      check($sformatf("%s valid%0d", tag, t), W'(bus.out_valid), 1);
      check($sformatf("%s beat%0d", tag, t), bus.a_out, exp_beat(t));
      check($sformatf("%s done%0d", tag, t), W'(bus.done), 0);
      if (junk) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = '1;
        bus.start   = 1'b1;
      end
      tick();
    end
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    check({tag, " done"}, W'(bus.done), 1);
    check({tag, " end valid"}, W'(bus.out_valid), 0);
    check({tag, " end a_out"}, bus.a_out, 0);
    check({tag, " end wr_ready"}, W'(bus.wr_ready), 1);
  endtask

  initial begin
    rst         = 1'b1;
    bus.clr     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    tick();
    tick();
    check("rst wr_ready", W'(bus.wr_ready), 1);
    check("rst full", W'(bus.full), 0);
    check("rst valid", W'(bus.out_valid), 0);
    check("rst a_out", bus.a_out, 0);
    check("rst done", W'(bus.done), 0);
    rst = 1'b0;
    tick();

    set_tile(0);
    for (int r = 0; r < DIM - 1; r++)
      write_row(r);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("idle start valid", W'(bus.out_valid), 0);
    tick();
    check("idle start valid2", W'(bus.out_valid), 0);
    check("partial full", W'(bus.full), 0);
    check("partial wr_ready", W'(bus.wr_ready), 1);
    write_row(DIM - 1);
    check("load full", W'(bus.full), 1);
    check("load wr_ready", W'(bus.wr_ready), 0);
    bus.wr_en   = 1'b1;
    bus.wr_data = '1;
    tick();
    bus.wr_en = 1'b0;
    check("full ignores wr", W'(bus.full), 1);
    run_stream("basic", 1'b1);
    check("basic hand b0", beats[0], 32'h0000_0000);
    check("basic hand b3", beats[3], 32'h0312_2130);
    check("basic hand b6", beats[6], 32'h3300_0000);

    tile_m[0] = 32'h8080_8080;
    for (int r = 1; r < DIM; r++)
      tile_m[r] = 32'h7F7F_7F7F;
    load_tile("signed");
    run_stream("signed", 1'b0);
    check("signed b0", beats[0], 32'h0000_0080);
    check("signed lane0 b1", W'(beats[1][7:0]), 32'h7F);
    check("signed lane0 b3", W'(beats[3][7:0]), 32'h7F);
    check("signed lane0 b4", W'(beats[4][7:0]), 32'h00);
    check("signed b6", beats[6], 32'h7F00_0000);

    set_tile(8'h40);
    load_tile("clr pre");
    bus.clr   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.clr   = 1'b0;
    bus.start = 1'b0;
    check("clr valid", W'(bus.out_valid), 0);
    check("clr full", W'(bus.full), 0);
    check("clr wr_ready", W'(bus.wr_ready), 1);
    tick();
    check("clr valid2", W'(bus.out_valid), 0);
    set_tile(8'h50);
    load_tile("after clr");
    run_stream("after clr", 1'b0);

    set_tile(8'h10);
    load_tile("arst pre");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("arst pre beat3", bus.a_out, exp_beat(3));
    #2;
    rst = 1'b1;
    #1;
    check("arst a_out", bus.a_out, 0);
    check("arst valid", W'(bus.out_valid), 0);
    check("arst done", W'(bus.done), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("arst wr_ready", W'(bus.wr_ready), 1);
    check("arst full", W'(bus.full), 0);
    check("arst valid after", W'(bus.out_valid), 0);
    set_tile(8'h20);
    load_tile("after arst");
    run_stream("after arst", 1'b0);

    set_tile(0);
    load_tile("b2b first");
    run_stream("b2b first", 1'b0);
    set_tile(8'h88);
    load_tile("b2b second");
    run_stream("b2b second", 1'b0);
    check("b2b hand b3", beats[3], 32'h8B9A_A9B8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
